// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
// Parity modes, rx state encoding and parameter legality.
package serial_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic bit cfg_ok(
    int dw,
    int pm,
    int cpb,
    int sb
  );
    return (dw >= 5) && (dw <= 16) &&
           (pm >= PAR_NONE) && (pm <= PAR_ODD) &&
           (cpb >= 1) &&
           (sb >= 0) && (sb <= 2);
  endfunction

endpackage

// File: rtl/serial_rx_frame_if.sv
// Output handshake bundle of the serial frame receiver.
// master = receiver side, slave = consumer side.
interface serial_rx_frame_if #(
  parameter int DATA_W = 7
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              parity_err;
  logic              frame_err;

  modport master (
    output out_valid,
    output data_out,
    output parity_err,
    output frame_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  data_out,
    input  parity_err,
    input  frame_err,
    output out_ready
  );
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period tick generator for the serial receiver.
// start arms the first sample, run keeps sampling each period.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic run,
  output logic tick
);
  localparam int TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H = (CLKS_PER_BIT - 1) / 2;

  localparam logic [TW-1:0] RELOAD =
    TW'(CLKS_PER_BIT - 1);
  // H cycles out from the start edge; with H = 0 the
  // start edge is itself the sample, so reload instead.
  localparam logic [TW-1:0] FIRST =
    (H == 0) ? RELOAD : TW'(H - 1);

  logic [TW-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= FIRST;
    end else if (run) begin
      cnt <= tick ? RELOAD : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/serial_rx_frame.sv
// Parametrised serial frame receiver with mid-bit sampling,
// parity/framing checks and valid/ready output.
module serial_rx_frame
  import serial_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int PARITY_MODE  = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic serial_in,
  input  logic clr_overrun,
  serial_rx_frame_if.master rx,
  output logic overrun,
  output logic busy
);
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int BW = $clog2(DATA_W + 1);
  localparam bit HAS_PAR = (PARITY_MODE != PAR_NONE);

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  if (!cfg_ok(DATA_W, PARITY_MODE,
              CLKS_PER_BIT, STOP_BITS)) begin : g_cfg_err
    $error("serial_rx_frame: parameter out of range");
  end

  rx_state_t         state, state_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [1:0]        stop_cnt, stop_cnt_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              pbit, pbit_nxt;
  logic              ferr, ferr_nxt;
  logic              tmr_start, tmr_run, tick;
  logic              done, perr_calc;

  logic              vld_q, perr_q, ferr_q, ovr_q;
  logic [DATA_W-1:0] data_q;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tmr (
    .clk  (clk),
    .rstn (rstn),
    .start(tmr_start),
    .run  (tmr_run),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      sh       <= '0;
      pbit     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      sh       <= sh_nxt;
      pbit     <= pbit_nxt;
      ferr     <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    sh_nxt       = sh;
    pbit_nxt     = pbit;
    ferr_nxt     = ferr;
    tmr_start    = 1'b0;
    tmr_run      = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!serial_in) begin
          tmr_start    = 1'b1;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = '0;
          pbit_nxt     = 1'b0;
          ferr_nxt     = 1'b0;
          state_nxt    = (H == 0) ? DATA : START;
        end
      end
      START: begin
        tmr_run = 1'b1;
        if (tick) begin
          state_nxt = serial_in ? IDLE : DATA;
        end
      end
      DATA: begin
        tmr_run = 1'b1;
        if (tick) begin
          sh_nxt = {serial_in, sh[DATA_W-1:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            if (HAS_PAR) state_nxt = PARITY;
            else if (STOP_BITS > 0) state_nxt = STOP;
            else done = 1'b1;
          end
        end
      end
      PARITY: begin
        tmr_run = 1'b1;
        if (tick) begin
          pbit_nxt = serial_in;
          if (STOP_BITS > 0) state_nxt = STOP;
          else done = 1'b1;
        end
      end
      STOP: begin
        tmr_run = 1'b1;
        if (tick) begin
          if (!serial_in) ferr_nxt = 1'b1;
          stop_cnt_nxt = stop_cnt + 1'b1;
          if (stop_cnt == LAST_STOP) done = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (serial_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A broken frame must see the line recover before rearming.
    if (done) state_nxt = ferr_nxt ? WAIT_HIGH : IDLE;
  end

  always_comb begin
    perr_calc = 1'b0;
    if (PARITY_MODE == PAR_EVEN)
      perr_calc = ^sh_nxt ^ pbit_nxt;
    else if (PARITY_MODE == PAR_ODD)
      perr_calc = ~(^sh_nxt ^ pbit_nxt);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (done) begin
        vld_q  <= 1'b1;
        data_q <= sh_nxt;
        perr_q <= perr_calc;
        ferr_q <= ferr_nxt;
      end else if (vld_q && rx.out_ready) begin
        vld_q <= 1'b0;
      end
      if (done && vld_q && !rx.out_ready)
        ovr_q <= 1'b1;
      else if (clr_overrun)
        ovr_q <= 1'b0;
    end
  end

  assign rx.out_valid  = vld_q;
  assign rx.data_out   = data_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_rx_frame.sv
// Bench for serial_rx_frame: four configurations, directed
// corner cases plus random frames against a frame-level model.
module tb_serial_rx_frame;
  import serial_pkg::*;

  localparam int NC = 4;
  localparam int DW  [NC] = '{7, 8, 7, 16};
  localparam int PM  [NC] = '{1, 2, 1, 0};
  localparam int CPB [NC] = '{1, 16, 4, 3};
  localparam int SB  [NC] = '{1, 1, 2, 0};

  typedef struct {
    int          c;
    logic [15:0] d;
    logic        pe;
    logic        fe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        line [NC];
  logic        rdy  [NC];
  logic        clr  [NC];
  logic        ov   [NC];
  logic [15:0] dout [NC];
  logic        perr [NC];
  logic        ferr [NC];
  logic        ovr  [NC];
  logic        bsy  [NC];

  int nvec = 0;
  int nerr = 0;
  int vcyc [NC] = '{default: 0};
  int acc  [NC] = '{default: 0};
  logic [15:0] last_d  [NC];
  logic        last_pe [NC];
  logic        last_fe [NC];
  exp_t expq [$];

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    serial_rx_frame_if #(.DATA_W(DW[g])) bus ();
    assign bus.out_ready = rdy[g];
    assign ov[g]   = bus.out_valid;
    assign dout[g] = 16'(bus.data_out);
    assign perr[g] = bus.parity_err;
    assign ferr[g] = bus.frame_err;
    serial_rx_frame #(
      .DATA_W      (DW[g]),
      .PARITY_MODE (PM[g]),
      .CLKS_PER_BIT(CPB[g]),
      .STOP_BITS   (SB[g])
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .serial_in  (line[g]),
      .clr_overrun(clr[g]),
      .rx         (bus.master),
      .overrun    (ovr[g]),
      .busy       (bsy[g])
    );
  end

  task automatic chk(string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int c,
                                 logic [15:0] d,
                                 logic pb,
                                 logic [1:0] st);
    exp_t e;
    int ones;
    e.c  = c;
    e.d  = d & 16'((32'd1 << DW[c]) - 1);
    ones = $countones(e.d) + int'(pb);
    if (PM[c] == 0)      e.pe = 1'b0;
    else if (PM[c] == 1) e.pe = 1'(ones % 2);
    else                 e.pe = 1'((ones + 1) % 2);
    e.fe = (SB[c] >= 1 && !st[0]) ||
           (SB[c] == 2 && !st[1]);
    return e;
  endfunction

  // Words are judged the cycle before they are consumed.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      if (ov[i] === 1'b1) vcyc[i]++;
      if (ov[i] === 1'b1 && rdy[i] === 1'b1) begin
        acc[i]++;
        last_d[i]  = dout[i];
        last_pe[i] = perr[i];
        last_fe[i] = ferr[i];
        chk($sformatf("cfg%0d_word_expected", i),
            32'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk($sformatf("cfg%0d_cfg_id", i), i, e.c);
          chk($sformatf("cfg%0d_data", i), dout[i], e.d);
          chk($sformatf("cfg%0d_perr", i), perr[i], e.pe);
          chk($sformatf("cfg%0d_ferr", i), ferr[i], e.fe);
        end
      end
    end
  end

  task automatic send(int c, logic [15:0] d, logic pb,
                      logic [1:0] st, bit push);
    logic b [$];
    b.push_back(1'b0);
    for (int k = 0; k < DW[c]; k++) b.push_back(d[k]);
    if (PM[c] != 0) b.push_back(pb);
    for (int k = 0; k < SB[c]; k++) b.push_back(st[k]);
    foreach (b[k]) begin
      if (push && k == b.size() - 1)
        expq.push_back(model(c, d, pb, st));
      line[c] = b[k];
      repeat (CPB[c]) @(negedge clk);
    end
  endtask

  task automatic set_rdy(int c, logic v);
    @(posedge clk);
    #1 rdy[c] = v;
    @(negedge clk);
  endtask

  task automatic rand_frames(int c, int n);
    logic [15:0] d;
    logic        pb;
    logic [1:0]  st;
    exp_t        e;
    for (int f = 0; f < n; f++) begin
      d  = 16'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ?
           2'($urandom) : 2'b11;
      e  = model(c, d, pb, st);
      send(c, d, pb, st, 1'b1);
      line[c] = 1'b1;
      if (e.fe || SB[c] == 0)
        repeat (2 * CPB[c] + 1) @(negedge clk);
      else
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2 * CPB[c] + 2) @(negedge clk);
    chk($sformatf("cfg%0d_drained", c), expq.size(), 0);
    chk($sformatf("cfg%0d_idle", c), bsy[c], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no end of test");
    $fatal(1);
  end

  initial begin
    int a0, v0;
    rstn = 1'b0;
    for (int i = 0; i < NC; i++) begin
      line[i] = 1'b1;
      rdy[i]  = 1'b1;
      clr[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("rst%0d_valid", i), ov[i], 0);
      chk($sformatf("rst%0d_data", i), dout[i], 0);
      chk($sformatf("rst%0d_perr", i), perr[i], 0);
      chk($sformatf("rst%0d_ferr", i), ferr[i], 0);
      chk($sformatf("rst%0d_ovr", i), ovr[i], 0);
      chk($sformatf("rst%0d_busy", i), bsy[i], 0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    v0 = vcyc[0];
    send(0, 16'h55, 1'b0, 2'b11, 1'b1);
    line[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("p55_valid_cycles", vcyc[0] - v0, 1);
    chk("p55_data", last_d[0], 16'h55);
    chk("p55_perr", last_pe[0], 0);
    chk("p55_ferr", last_fe[0], 0);

    send(0, 16'h55, 1'b1, 2'b11, 1'b1);
    line[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("p55b_data", last_d[0], 16'h55);
    chk("p55b_perr", last_pe[0], 1);

    set_rdy(0, 1'b0);
    send(0, 16'h12, 1'b0, 2'b11, 1'b0);
    line[0] = 1'b1;
    @(negedge clk);
    send(0, 16'h34, 1'b1, 2'b11, 1'b0);
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_valid", ov[0], 1);
    chk("ovr_data", dout[0], 16'h34);
    chk("ovr_perr", perr[0], 0);
    chk("ovr_flag", ovr[0], 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovr_cleared", ovr[0], 0);
    chk("ovr_still_valid", ov[0], 1);
    expq.push_back('{0, 16'h34, 1'b0, 1'b0});
    set_rdy(0, 1'b1);
    @(negedge clk);
    chk("ovr_drained", ov[0], 0);

    a0 = acc[0];
    send(0, 16'h2A, 1'b1, 2'b00, 1'b1);
    repeat (12) @(negedge clk);
    chk("fe_busy_low", bsy[0], 1);
    chk("fe_one_word", acc[0] - a0, 1);
    chk("fe_flag", last_fe[0], 1);
    chk("fe_data", last_d[0], 16'h2A);
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("fe_recovered", bsy[0], 0);

    rand_frames(0, 20);

    line[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("fs_busy", bsy[1], 1);
    line[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("fs_idle", bsy[1], 0);
    chk("fs_no_word", acc[1], 0);
    send(1, 16'hA3, 1'b1, 2'b11, 1'b1);
    line[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("a3_data", last_d[1], 16'hA3);
    chk("a3_perr", last_pe[1], 0);
    rand_frames(1, 6);

    set_rdy(2, 1'b0);
    send(2, 16'h5A, 1'b0, 2'b11, 1'b0);
    line[2] = 1'b1;
    @(negedge clk);
    send(2, 16'h2C, 1'b1, 2'b11, 1'b0);
    line[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", ov[2], 1);
    chk("pre_rst_data", dout[2], 16'h2C);
    chk("pre_rst_ovr", ovr[2], 1);
    line[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      line[2] = 1'($urandom);
      repeat (4) @(negedge clk);
    end
    chk("mid_busy", bsy[2], 1);
    rstn = 1'b0;
    #1;
    chk("arst_valid", ov[2], 0);
    chk("arst_data", dout[2], 0);
    chk("arst_perr", perr[2], 0);
    chk("arst_ferr", ferr[2], 0);
    chk("arst_ovr", ovr[2], 0);
    chk("arst_busy", bsy[2], 0);
    @(negedge clk);
    line[2] = 1'b1;
    rstn = 1'b1;
    set_rdy(2, 1'b1);
    send(2, 16'h7F, 1'b1, 2'b11, 1'b1);
    line[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("p7f_data", last_d[2], 16'h7F);
    chk("p7f_perr", last_pe[2], 0);
    rand_frames(2, 8);

    rand_frames(3, 8);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
